// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings: transfer types, transfer sizes and response codes.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HWORD = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011,
        HSIZE_4WORD = 3'b100,
        HSIZE_8WORD = 3'b101,
        HSIZE_512   = 3'b110,
        HSIZE_1024  = 3'b111
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // True for transfer types that carry a real address phase.
    function automatic logic is_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb3lite_be_gen.sv
// Byte-lane enable generator: transfer size plus byte offset within the bus
// word gives a little-endian lane mask, with the offset truncated down to
// the size boundary.
module ahb3lite_be_gen
    import ahb3lite_pkg::*;
#(
    parameter  int HDATA_SIZE = 32,
    localparam int NBYTES     = HDATA_SIZE / 8,
    localparam int BYTE_AW    = $clog2(NBYTES)
) (
    input  logic [2:0]         hsize_i,
    input  logic [BYTE_AW-1:0] offset_i,
    output logic [NBYTES-1:0]  be_o
);

    // Lanes [base, base + nbytes) are enabled; oversize requests enable all lanes.
    always_comb begin : gen_mask
        int nbytes;
        int base;
        // NOTE: every variable written here gets a value first so no path can infer a latch.
        be_o   = '0;
        nbytes = (int'(hsize_i) > BYTE_AW) ? NBYTES : (1 << hsize_i);
        base   = int'(offset_i) & ~(nbytes - 1);
        for (int i = 0; i < NBYTES; i++) begin
            be_o[i] = (i >= base) && (i < base + nbytes);
        end
    end

endmodule

// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite single-port memory slave with configurable wait states,
// byte-lane writes, read-after-write forwarding and a two-cycle ERROR
// response for out-of-range or oversize transfers.
module ahb3lite_mem_slave
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 16,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int NBYTES  = HDATA_SIZE / 8;
    localparam int BYTE_AW = $clog2(NBYTES);
    localparam int MEM_AW  = $clog2(MEM_DEPTH);

    localparam logic [2:0]          MAX_HSIZE = 3'(BYTE_AW);
    localparam logic [HADDR_SIZE:0] DEPTH_W   = (HADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [2:0]          WAIT_LAST = 3'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t                  state_q;
    logic [2:0]              wait_cnt_q;
    logic [MEM_AW-1:0]       idx_q;
    logic [BYTE_AW-1:0]      off_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic                    hreadyout_q;
    logic                    hresp_q;
    logic [HDATA_SIZE-1:0]   hrdata_q;

    logic [HDATA_SIZE-1:0]   mem [MEM_DEPTH];

    logic                    accept;
    logic                    illegal;
    logic [HADDR_SIZE-1:0]   addr_word;
    logic [MEM_AW-1:0]       haddr_idx;
    logic [MEM_AW-1:0]       rd_idx;
    logic                    mem_we;
    logic [NBYTES-1:0]       be;
    logic [HDATA_SIZE-1:0]   rd_word_d;
    logic                    unused_inputs;

    // Burst type, protection and lock carry no meaning for a plain memory.
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

    assign accept    = HSEL && HREADY && is_active(HTRANS);
    assign addr_word = HADDR >> BYTE_AW;
    assign illegal   = ({1'b0, addr_word} >= DEPTH_W) || (HSIZE > MAX_HSIZE);
    assign haddr_idx = HADDR[BYTE_AW +: MEM_AW];
    assign mem_we    = (state_q == ST_DATA) && write_q;
    assign rd_idx    = (state_q == ST_WAIT) ? idx_q : haddr_idx;

    ahb3lite_be_gen #(
        .HDATA_SIZE (HDATA_SIZE)
    ) u_be_gen (
        .hsize_i  (size_q),
        .offset_i (off_q),
        .be_o     (be)
    );

    // Read word for the beat entering DATA, merged with a write retiring on the same edge.
    always_comb begin
        rd_word_d = mem[rd_idx];
        if (mem_we && (idx_q == rd_idx)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) rd_word_d[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // Memory write port: enabled lanes commit at the edge that ends a write DATA cycle.
    // NOTE: the array has no reset; contents survive HRESET and it maps onto plain RAM.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    // Transfer FSM with registered HREADYOUT / HRESP / HRDATA.
    // NOTE: state is updated with <= so every register samples the pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            idx_q       <= '0;
            off_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept) begin
                        idx_q   <= haddr_idx;
                        off_q   <= HADDR[BYTE_AW-1:0];
                        write_q <= HWRITE;
                        size_q  <= HSIZE;
                        if (illegal) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state_q     <= ST_WAIT;
                            wait_cnt_q  <= '0;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_OKAY;
                        end else begin
                            state_q     <= ST_DATA;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= HRESP_OKAY;
                            if (!HWRITE) hrdata_q <= rd_word_d;
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q     <= ST_DATA;
                        wait_cnt_q  <= '0;
                        hreadyout_q <= 1'b1;
                        if (!write_q) hrdata_q <= rd_word_d;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + 3'd1;
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    wait_cnt_q  <= '0;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Directed bench for ahb3lite_mem_slave: a zero-wait instance and a
// two-wait-state instance, each the only slave on its bus.
module tb_ahb3lite_mem_slave;
    import ahb3lite_pkg::*;

    logic        clk;
    logic        hreset;
    logic        hsel0;
    logic        hsel1;
    logic [15:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hrdata0;
    logic [31:0] hrdata1;
    logic        hreadyout0;
    logic        hreadyout1;
    logic        hresp0;
    logic        hresp1;

    int total;
    int bad;

    localparam logic [31:0] BURST [4] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};

    ahb3lite_mem_slave #(
        .HADDR_SIZE (16), .HDATA_SIZE (32), .MEM_DEPTH (256), .WAIT_STATES (0)
    ) u_ws0 (
        .HCLK (clk), .HRESET (hreset), .HSEL (hsel0), .HADDR (haddr),
        .HWDATA (hwdata), .HRDATA (hrdata0), .HWRITE (hwrite), .HSIZE (hsize),
        .HBURST (hburst), .HPROT (hprot), .HTRANS (htrans), .HMASTLOCK (hmastlock),
        .HREADY (hreadyout0), .HREADYOUT (hreadyout0), .HRESP (hresp0)
    );

    ahb3lite_mem_slave #(
        .HADDR_SIZE (16), .HDATA_SIZE (32), .MEM_DEPTH (256), .WAIT_STATES (2)
    ) u_ws2 (
        .HCLK (clk), .HRESET (hreset), .HSEL (hsel1), .HADDR (haddr),
        .HWDATA (hwdata), .HRDATA (hrdata1), .HWRITE (hwrite), .HSIZE (hsize),
        .HBURST (hburst), .HPROT (hprot), .HTRANS (htrans), .HMASTLOCK (hmastlock),
        .HREADY (hreadyout1), .HREADYOUT (hreadyout1), .HRESP (hresp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NOTE: inputs change 1 ns after the rising edge with blocking assignments; outputs are sampled on the falling edge.
    task automatic drive(input logic s0, input logic s1, input logic [1:0] tr,
                         input logic [15:0] a, input logic w, input logic [2:0] sz);
        hsel0  = s0;
        hsel1  = s1;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (hreadyout0 !== 1'b1) begin bad++; $display("FAIL rst_ready0: got %b want 1", hreadyout0); end
        total++; if (hresp0 !== 1'b0) begin bad++; $display("FAIL rst_resp0: got %b want 0", hresp0); end
        total++; if (hrdata0 !== 32'h0) begin bad++; $display("FAIL rst_rdata0: got %h want 0", hrdata0); end
        total++; if (hreadyout1 !== 1'b1) begin bad++; $display("FAIL rst_ready1: got %b want 1", hreadyout1); end
        total++; if (u_ws2.state_q !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0 (IDLE)", u_ws2.state_q); end
        total++; if (u_ws2.wait_cnt_q !== 3'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", u_ws2.wait_cnt_q); end
        @(posedge clk);
        #1 hreset = 1'b0;
    endtask

    task automatic test_write_read;
        drive(1, 0, HTRANS_NONSEQ, 16'h0010, 1, HSIZE_WORD);
        @(negedge clk);
        total++; if (hreadyout0 !== 1'b1) begin bad++; $display("FAIL wr_addr_ready: got %b want 1", hreadyout0); end
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0010, 0, HSIZE_WORD);
        hwdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (hreadyout0 !== 1'b1) begin bad++; $display("FAIL wr_data_ready: got %b want 1", hreadyout0); end
        total++; if (hresp0 !== 1'b0) begin bad++; $display("FAIL wr_data_resp: got %b want 0", hresp0); end
        step;
        drive(1, 0, HTRANS_BUSY, 16'h0000, 0, HSIZE_WORD);
        @(negedge clk);
        total++; if (hrdata0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_read: got %h want deadbeef", hrdata0); end
        total++; if (hreadyout0 !== 1'b1) begin bad++; $display("FAIL rd_ready: got %b want 1", hreadyout0); end
        total++; if (hresp0 !== 1'b0) begin bad++; $display("FAIL rd_resp: got %b want 0", hresp0); end
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        @(negedge clk);
        total++; if (hrdata0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hold: got %h want deadbeef", hrdata0); end
        total++; if (hreadyout0 !== 1'b1 || hresp0 !== 1'b0) begin bad++; $display("FAIL busy_okay: got ready=%b resp=%b want 1/0", hreadyout0, hresp0); end
        step;
    endtask

    task automatic test_byte_lanes;
        drive(1, 0, HTRANS_NONSEQ, 16'h0010, 1, HSIZE_WORD);
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0013, 1, HSIZE_BYTE);
        hwdata = 32'h1122_3344;
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0010, 0, HSIZE_WORD);
        hwdata = 32'hAB55_5555;
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0014, 1, HSIZE_WORD);
        @(negedge clk);
        total++; if (hrdata0 !== 32'hAB22_3344) begin bad++; $display("FAIL byte_fwd: got %h want ab223344", hrdata0); end
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0017, 1, HSIZE_HWORD);
        hwdata = 32'h0000_0000;
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0014, 1, HSIZE_BYTE);
        hwdata = 32'hBEEF_1234;
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        hwdata = 32'h7777_77C3;
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0014, 0, HSIZE_WORD);
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0010, 0, HSIZE_WORD);
        @(negedge clk);
        total++; if (hrdata0 !== 32'hBEEF_00C3) begin bad++; $display("FAIL hword_misalign: got %h want beef00c3", hrdata0); end
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        @(negedge clk);
        total++; if (hrdata0 !== 32'hAB22_3344) begin bad++; $display("FAIL mem_read: got %h want ab223344", hrdata0); end
        step;
    endtask

    task automatic test_error;
        drive(1, 0, HTRANS_NONSEQ, 16'h0000, 1, HSIZE_WORD);
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h03FC, 1, HSIZE_WORD);
        hwdata = 32'h0BAD_F00D;
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0400, 1, HSIZE_WORD);
        hwdata = 32'hCAFE_F00D;
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        hwdata = 32'h1234_5678;
        @(negedge clk);
        total++; if (hreadyout0 !== 1'b0) begin bad++; $display("FAIL err1_ready: got %b want 0", hreadyout0); end
        total++; if (hresp0 !== 1'b1) begin bad++; $display("FAIL err1_resp: got %b want 1", hresp0); end
        step;
        @(negedge clk);
        total++; if (hreadyout0 !== 1'b1) begin bad++; $display("FAIL err2_ready: got %b want 1", hreadyout0); end
        total++; if (hresp0 !== 1'b1) begin bad++; $display("FAIL err2_resp: got %b want 1", hresp0); end
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0000, 0, HSIZE_WORD);
        @(negedge clk);
        total++; if (hresp0 !== 1'b0 || hreadyout0 !== 1'b1) begin bad++; $display("FAIL err_recover: got ready=%b resp=%b want 1/0", hreadyout0, hresp0); end
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h03FC, 0, HSIZE_WORD);
        @(negedge clk);
        total++; if (hrdata0 !== 32'h0BAD_F00D) begin bad++; $display("FAIL err_no_write: got %h want 0badf00d", hrdata0); end
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0010, 1, HSIZE_DWORD);
        @(negedge clk);
        total++; if (hrdata0 !== 32'hCAFE_F00D) begin bad++; $display("FAIL last_word: got %h want cafef00d", hrdata0); end
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++; if (hreadyout0 !== 1'b0 || hresp0 !== 1'b1) begin bad++; $display("FAIL size_err1: got ready=%b resp=%b want 0/1", hreadyout0, hresp0); end
        step;
        @(negedge clk);
        total++; if (hreadyout0 !== 1'b1 || hresp0 !== 1'b1) begin bad++; $display("FAIL size_err2: got ready=%b resp=%b want 1/1", hreadyout0, hresp0); end
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'hFFFC, 1, HSIZE_WORD);
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        hwdata = 32'h0000_0000;
        @(negedge clk);
        total++; if (hresp0 !== 1'b1) begin bad++; $display("FAIL wide_addr_err: got %b want 1", hresp0); end
        step;
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0010, 0, HSIZE_WORD);
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h03FC, 0, HSIZE_WORD);
        @(negedge clk);
        total++; if (hrdata0 !== 32'hAB22_3344) begin bad++; $display("FAIL size_err_no_write: got %h want ab223344", hrdata0); end
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        @(negedge clk);
        total++; if (hrdata0 !== 32'hCAFE_F00D) begin bad++; $display("FAIL wide_no_write: got %h want cafef00d", hrdata0); end
        step;
    endtask

    task automatic test_wait_burst;
        int   issued;
        int   done;
        int   cycles;
        int   low;
        int   low_beat;
        logic hr;
        logic wr;
        for (int pass = 0; pass < 2; pass++) begin
            wr = (pass == 0);
            drive(0, 1, HTRANS_NONSEQ, 16'h0020, wr, HSIZE_WORD);
            step;
            issued   = 1;
            done     = 0;
            cycles   = 0;
            low      = 0;
            low_beat = 0;
            drive(0, 1, HTRANS_SEQ, 16'h0024, wr, HSIZE_WORD);
            hwdata = BURST[0];
            while (done < 4 && cycles < 40) begin
                @(negedge clk);
                cycles++;
                hr = hreadyout1;
                if (!hr) begin
                    low++;
                    low_beat++;
                end else begin
                    total++; if (low_beat !== 2) begin bad++; $display("FAIL beat_wait pass%0d beat%0d: got %0d want 2", pass, done, low_beat); end
                    total++; if (hresp1 !== 1'b0) begin bad++; $display("FAIL beat_resp pass%0d beat%0d: got %b want 0", pass, done, hresp1); end
                    if (!wr) begin
                        total++; if (hrdata1 !== BURST[done]) begin bad++; $display("FAIL burst_rdata beat%0d: got %h want %h", done, hrdata1, BURST[done]); end
                    end
                    done++;
                    low_beat = 0;
                end
                step;
                if (hr) begin
                    if (issued < 4) issued++;
                    if (issued < 4) drive(0, 1, HTRANS_SEQ, 16'h0020 + 16'(4 * issued), wr, HSIZE_WORD);
                    else drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
                    if (done < 4) hwdata = BURST[done];
                end
            end
            total++; if (done !== 4) begin bad++; $display("FAIL burst_timeout pass%0d: got %0d beats want 4", pass, done); end
            total++; if (cycles !== 12) begin bad++; $display("FAIL burst_cycles pass%0d: got %0d want 12", pass, cycles); end
            total++; if (low !== 8) begin bad++; $display("FAIL burst_low pass%0d: got %0d want 8", pass, low); end
        end
    endtask

    task automatic test_reset_wait;
        int n;
        drive(0, 1, HTRANS_NONSEQ, 16'h0030, 1, HSIZE_WORD);
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        hwdata = 32'h5A5A_5A5A;
        n = 0;
        @(negedge clk);
        while (!hreadyout1 && n < 10) begin @(negedge clk); n++; end
        total++; if (hreadyout1 !== 1'b1) begin bad++; $display("FAIL pre_write_timeout: got ready=%b want 1", hreadyout1); end
        step;
        drive(0, 1, HTRANS_NONSEQ, 16'h0030, 1, HSIZE_WORD);
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++; if (hreadyout1 !== 1'b0) begin bad++; $display("FAIL in_wait: got ready=%b want 0", hreadyout1); end
        #1 hreset = 1'b1;
        #1;
        total++; if (hreadyout1 !== 1'b1) begin bad++; $display("FAIL rst_async_ready: got %b want 1", hreadyout1); end
        @(posedge clk);
        #1 hreset = 1'b0;
        @(negedge clk);
        total++; if (hreadyout1 !== 1'b1) begin bad++; $display("FAIL rst_wait_ready: got %b want 1", hreadyout1); end
        total++; if (u_ws2.state_q !== 3'd0) begin bad++; $display("FAIL rst_wait_state: got %0d want 0 (IDLE)", u_ws2.state_q); end
        total++; if (u_ws2.wait_cnt_q !== 3'd0) begin bad++; $display("FAIL rst_wait_cnt: got %0d want 0", u_ws2.wait_cnt_q); end
        step;
        drive(0, 1, HTRANS_NONSEQ, 16'h0030, 0, HSIZE_WORD);
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        n = 0;
        @(negedge clk);
        while (!hreadyout1 && n < 10) begin @(negedge clk); n++; end
        total++; if (hreadyout1 !== 1'b1) begin bad++; $display("FAIL post_read_timeout: got ready=%b want 1", hreadyout1); end
        total++; if (hrdata1 !== 32'h5A5A_5A5A) begin bad++; $display("FAIL rst_no_write: got %h want 5a5a5a5a", hrdata1); end
        step;
        drive(1, 0, HTRANS_NONSEQ, 16'h0010, 0, HSIZE_WORD);
        step;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        @(negedge clk);
        total++; if (hrdata0 !== 32'hAB22_3344) begin bad++; $display("FAIL mem_kept: got %h want ab223344", hrdata0); end
        step;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        hreset    = 1'b1;
        hburst    = 3'b011;
        hprot     = 4'b0011;
        hmastlock = 1'b0;
        hwdata    = 32'h0;
        drive(0, 0, HTRANS_IDLE, 16'h0000, 0, HSIZE_WORD);
        test_reset;
        test_write_read;
        test_byte_lanes;
        test_error;
        test_wait_burst;
        test_reset_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
